// File: rtl/div_cell_seq_7.sv
// Restoring divider, one quotient bit per clock; rdy pulses 17 cycles after an accepted start (divide-by-zero: 1 cycle).
// start is taken only while idle or in the result cycle, and is ignored while busy.
module div_cell_seq_7 #(
   parameter int DIVIDEND_W = 16,
   parameter int DIVISOR_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  rdy,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero
);

   localparam int CNT_W = (DIVIDEND_W > 2) ? $clog2(DIVIDEND_W) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [DIVIDEND_W-1:0]   dq_q;
   logic [DIVISOR_W-1:0]    dsr_q;
   logic [DIVISOR_W-1:0]    p_q;
   logic [DIVIDEND_W-1:0]   quotient_q;
   logic [DIVISOR_W-1:0]    remainder_q;
   logic                    dbz_q;
   logic                    busy_q;
   logic                    rdy_q;

   logic [DIVISOR_W:0]      t_w;
   logic                    ge_w;
   logic [DIVISOR_W-1:0]    p_d;
   logic [DIVIDEND_W-1:0]   dq_d;

   // The partial remainder is always below the divisor, so its extra top bit is
   // only ever live inside the trial value t_w and need not be stored.
   // dq_q holds the unconsumed dividend bits and collects quotient bits at the LSB.
   always_comb begin
      t_w  = {p_q, dq_q[DIVIDEND_W-1]};
      ge_w = (t_w >= {1'b0, dsr_q});
      p_d  = t_w[DIVISOR_W-1:0];
      if (ge_w) begin
         p_d = DIVISOR_W'(t_w - {1'b0, dsr_q});
      end
      dq_d = {dq_q[DIVIDEND_W-2:0], ge_w};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dq_q        <= '0;
         dsr_q       <= '0;
         p_q         <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         busy_q      <= 1'b0;
         rdy_q       <= 1'b0;
      end else begin
         rdy_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               if (start) begin
                  dq_q  <= dividend;
                  dsr_q <= divisor;
                  p_q   <= '0;
                  cnt_q <= CNT_W'(DIVIDEND_W - 1);
                  if (divisor == '0) begin
                     state_q     <= DONE;
                     rdy_q       <= 1'b1;
                     quotient_q  <= '1;
                     remainder_q <= '0;
                     dbz_q       <= 1'b1;
                  end else begin
                     state_q <= CALC;
                     busy_q  <= 1'b1;
                  end
               end
            end
            CALC: begin
               dq_q <= dq_d;
               p_q  <= p_d;
               if (cnt_q == '0) begin
                  state_q     <= DONE;
                  busy_q      <= 1'b0;
                  rdy_q       <= 1'b1;
                  quotient_q  <= dq_d;
                  remainder_q <= p_d;
                  dbz_q       <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign rdy         = rdy_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_cell_seq_7.sv
// Bench for div_cell_seq_7: vector table, hand-built corner sequences and random operands,
// with expected results queued at start and compared when rdy pulses.
module tb_div_cell_seq_7;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        busy;
   logic        rdy;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [15:0] dvd;
      logic [7:0]  dsr;
      logic [15:0] q;
      logic [7:0]  r;
      logic        dbz;
      int          lat;
   } vec_t;

   typedef struct {
      logic [15:0] q;
      logic [7:0]  r;
      logic        dbz;
   } res_t;

   res_t sb[$];
   vec_t tbl[11];

   div_cell_seq_7 dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .rdy(rdy), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic compare_pop(input string name);
      res_t e;
      if (sb.size() == 0) begin
         check({name, " unexpected rdy"}, 1, 0);
      end else begin
         e = sb.pop_front();
         check({name, " quotient"}, quotient, e.q);
         check({name, " remainder"}, remainder, e.r);
         check({name, " div_by_zero"}, div_by_zero, e.dbz);
      end
   endtask

   // Called #1 after the edge that sampled start; optionally pulses start with 9/2 mid-run.
   task automatic wait_rdy(input string name, input int lat, input int pulse_at);
      int cyc;
      cyc = 1;
      while (!rdy && cyc < 40) begin
         if (cyc == pulse_at) begin
            start = 1'b1; dividend = 16'd9; divisor = 8'd2;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      check({name, " latency"}, cyc, lat);
      if (rdy) compare_pop(name);
      else if (sb.size() != 0) void'(sb.pop_front());
   endtask

   task automatic do_op(input string name, input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] q, input logic [7:0] r, input logic dbz, input int lat);
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      sb.push_back('{q, r, dbz});
      @(posedge clk); #1;
      start = 1'b0;
      check({name, " busy"}, busy, (b != 0));
      wait_rdy(name, lat, 0);
      @(posedge clk); #1;
      check({name, " rdy single pulse"}, rdy, 0);
   endtask

   initial begin
      int seen;
      logic [15:0] ra;
      logic [7:0]  rb;

      tbl[0]  = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 17};
      tbl[1]  = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, 17};
      tbl[2]  = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 17};
      tbl[3]  = '{16'd5,     8'd9,   16'd0,     8'd5,   1'b0, 17};
      tbl[4]  = '{16'd0,     8'd3,   16'd0,     8'd0,   1'b0, 17};
      tbl[5]  = '{16'd1234,  8'd0,   16'hFFFF,  8'd0,   1'b1, 1};
      tbl[6]  = '{16'd100,   8'd10,  16'd10,    8'd0,   1'b0, 17};
      tbl[7]  = '{16'd255,   8'd255, 16'd1,     8'd0,   1'b0, 17};
      tbl[8]  = '{16'd65535, 8'd254, 16'd258,   8'd3,   1'b0, 17};
      tbl[9]  = '{16'd254,   8'd255, 16'd0,     8'd254, 1'b0, 17};
      tbl[10] = '{16'd40000, 8'd128, 16'd312,   8'd64,  1'b0, 17};

      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", busy, 0);
      check("reset rdy", rdy, 0);
      check("reset quotient", quotient, 0);
      check("reset remainder", remainder, 0);
      check("reset dbz", div_by_zero, 0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         do_op($sformatf("vec%0d", i), tbl[i].dvd, tbl[i].dsr, tbl[i].q, tbl[i].r,
               tbl[i].dbz, tbl[i].lat);
      end

      // start while busy is ignored, then a back-to-back start in the result cycle
      @(negedge clk);
      start = 1'b1; dividend = 16'd500; divisor = 8'd3;
      sb.push_back('{16'd166, 8'd2, 1'b0});
      @(posedge clk); #1;
      wait_rdy("busy_ignore", 17, 5);
      start = 1'b1; dividend = 16'd9; divisor = 8'd2;
      sb.push_back('{16'd4, 8'd1, 1'b0});
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b busy", busy, 1);
      check("b2b held quotient", quotient, 166);
      wait_rdy("b2b", 17, 0);
      @(posedge clk); #1;

      // reset mid-operation aborts without a result
      @(negedge clk);
      start = 1'b1; dividend = 16'd60000; divisor = 8'd13;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check("abort busy", busy, 0);
      check("abort rdy", rdy, 0);
      check("abort quotient", quotient, 0);
      check("abort remainder", remainder, 0);
      check("abort dbz", div_by_zero, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      seen = 0;
      repeat (25) begin @(posedge clk); #1; if (rdy) seen++; end
      check("abort no rdy", seen, 0);
      do_op("after_abort", 16'd60000, 8'd13, 16'd4615, 8'd5, 1'b0, 17);

      for (int i = 0; i < 2000; i++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = (i % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
         if (rb == 0) do_op("rand", ra, rb, 16'hFFFF, 8'd0, 1'b1, 1);
         else do_op("rand", ra, rb, ra / 16'(rb), 8'(ra % 16'(rb)), 1'b0, 17);
      end

      check("scoreboard empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
